// File: rtl/core_wb_bridge.sv
// Bridge from the core's valid/ready request bus to a Wishbone master, one transaction in flight.
// Optional macro WB_PIPELINED_EN selects B4 pipelined strobe handling; default is classic mode.
module core_wb_bridge #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                    sys_clk,
  input  logic                    rst_n,
  input  logic                    core_valid,
  input  logic                    core_we,
  input  logic [1:0]              core_size,
  input  logic [ADDR_WIDTH-1:0]   core_addr,
  input  logic [DATA_WIDTH-1:0]   core_wdata,
  output logic                    core_ready,
  output logic [DATA_WIDTH-1:0]   core_rdata,
  output logic                    core_err,
  output logic                    wb_cyc_o,
  output logic                    wb_stb_o,
  output logic                    wb_we_o,
  output logic [DATA_WIDTH/8-1:0] wb_sel_o,
  output logic [ADDR_WIDTH-1:0]   wb_adr_o,
  output logic [DATA_WIDTH-1:0]   wb_dat_o,
  input  logic [DATA_WIDTH-1:0]   wb_dat_i,
  input  logic                    wb_ack_i,
  input  logic                    wb_err_i,
  input  logic                    wb_stall_i
);

  localparam int unsigned BW   = DATA_WIDTH / 8;
  localparam int unsigned OffW = $clog2(BW);
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 2);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StBus, StResp} state_e;

  state_e                r_state, w_state_d;
  logic                  r_we, w_we_d;
  logic [1:0]            r_size, w_size_d;
  logic [OffW-1:0]       r_off, w_off_d;
  logic                  r_cyc, w_cyc_d;
  logic                  r_stb, w_stb_d;
  logic                  r_wb_we, w_wb_we_d;
  logic [BW-1:0]         r_sel, w_sel_d;
  logic [ADDR_WIDTH-1:0] r_adr, w_adr_d;
  logic [DATA_WIDTH-1:0] r_dat, w_dat_d;
  logic [CntW-1:0]       r_cnt, w_cnt_d;
  logic                  r_ready, w_ready_d;
  logic [DATA_WIDTH-1:0] r_rdata, w_rdata_d;
  logic                  r_err, w_err_d;

  logic [OffW-1:0]       w_off;
  logic [2:0]            w_off3;
  logic                  w_misaligned;
  logic [BW-1:0]         w_sel;
  logic [BW-1:0]         w_lane;
  logic [DATA_WIDTH-1:0] w_bitmask;
  logic [DATA_WIDTH-1:0] w_rd_aligned;

  function automatic logic [7:0] size_mask(input logic [1:0] size);
    case (size)
      2'd0:    return 8'h01;
      2'd1:    return 8'h03;
      2'd2:    return 8'h0f;
      default: return 8'hff;
    endcase
  endfunction

  assign w_off  = core_addr[OffW-1:0];
  assign w_off3 = 3'(w_off);
  assign w_sel  = BW'(size_mask(core_size)) << w_off;

  always_comb begin
    case (core_size)
      2'd0:    w_misaligned = 1'b0;
      2'd1:    w_misaligned = w_off3[0];
      2'd2:    w_misaligned = |w_off3[1:0];
      default: w_misaligned = (DATA_WIDTH == 32) || (|w_off3);
    endcase
  end

  // Read steering uses the size/offset latched at request time.
  assign w_lane       = BW'(size_mask(r_size));
  assign w_rd_aligned = wb_dat_i >> {r_off, 3'b000};

  always_comb begin
    w_bitmask = '0;
    for (int i = 0; i < int'(BW); i++) begin
      w_bitmask[8*i +: 8] = {8{w_lane[i]}};
    end
  end

`ifndef WB_PIPELINED_EN
  logic w_unused_stall;
  assign w_unused_stall = wb_stall_i;
`endif

  always_comb begin
    w_state_d = r_state;
    w_we_d    = r_we;
    w_size_d  = r_size;
    w_off_d   = r_off;
    w_cyc_d   = r_cyc;
    w_stb_d   = r_stb;
    w_wb_we_d = r_wb_we;
    w_sel_d   = r_sel;
    w_adr_d   = r_adr;
    w_dat_d   = r_dat;
    w_cnt_d   = r_cnt;
    w_ready_d = 1'b0;
    w_rdata_d = '0;
    w_err_d   = 1'b0;
    case (r_state)
      StIdle: begin
        if (core_valid) begin
          w_we_d   = core_we;
          w_size_d = core_size;
          w_off_d  = w_off;
          if (w_misaligned) begin
            w_state_d = StResp;
            w_ready_d = 1'b1;
            w_err_d   = 1'b1;
          end else begin
            w_state_d = StBus;
            w_cyc_d   = 1'b1;
            w_stb_d   = 1'b1;
            w_wb_we_d = core_we;
            w_sel_d   = w_sel;
            w_adr_d   = {core_addr[ADDR_WIDTH-1:OffW], {OffW{1'b0}}};
            w_dat_d   = core_wdata << {w_off, 3'b000};
            w_cnt_d   = '0;
          end
        end
      end
      StBus: begin
        w_cnt_d = r_cnt + CntW'(1);
`ifdef WB_PIPELINED_EN
        if (r_stb && !wb_stall_i) w_stb_d = 1'b0;
`endif
        if (wb_ack_i || wb_err_i ||
            ((TIMEOUT_CYCLES != 0) && (r_cnt == CntLast))) begin
          w_state_d = StResp;
          w_ready_d = 1'b1;
          w_cyc_d   = 1'b0;
          w_stb_d   = 1'b0;
          w_wb_we_d = 1'b0;
          w_sel_d   = '0;
          w_cnt_d   = '0;
          if (wb_ack_i) begin
            w_rdata_d = r_we ? '0 : (w_rd_aligned & w_bitmask);
          end else begin
            w_err_d = 1'b1;
          end
        end
      end
      StResp: w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_we    <= 1'b0;
      r_size  <= '0;
      r_off   <= '0;
      r_cyc   <= 1'b0;
      r_stb   <= 1'b0;
      r_wb_we <= 1'b0;
      r_sel   <= '0;
      r_adr   <= '0;
      r_dat   <= '0;
      r_cnt   <= '0;
      r_ready <= 1'b0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_we    <= w_we_d;
      r_size  <= w_size_d;
      r_off   <= w_off_d;
      r_cyc   <= w_cyc_d;
      r_stb   <= w_stb_d;
      r_wb_we <= w_wb_we_d;
      r_sel   <= w_sel_d;
      r_adr   <= w_adr_d;
      r_dat   <= w_dat_d;
      r_cnt   <= w_cnt_d;
      r_ready <= w_ready_d;
      r_rdata <= w_rdata_d;
      r_err   <= w_err_d;
    end
  end

  assign core_ready = r_ready;
  assign core_rdata = r_rdata;
  assign core_err   = r_err;
  assign wb_cyc_o   = r_cyc;
  assign wb_stb_o   = r_stb;
  assign wb_we_o    = r_wb_we;
  assign wb_sel_o   = r_sel;
  assign wb_adr_o   = r_adr;
  assign wb_dat_o   = r_dat;

endmodule
